// File: rtl/io_map_pkg.sv
// Address map and register bit positions of the memory-mapped I/O block.
// Also holds the address decode helper that the input port uses.
package io_map_pkg;

    localparam logic [31:0] IO_SW_ADDR     = 32'hC000_0000;
    localparam logic [31:0] IO_LEDS_ADDR   = 32'hC000_0004;
    localparam logic [31:0] IO_DISP_ADDR   = 32'hC000_0008;
    localparam logic [31:0] IO_LETTER_ADDR = 32'hC000_000C;
    localparam logic [31:0] IO_PB_ADDR     = 32'hC000_0010;
    localparam logic [31:0] IO_PBCNT_ADDR  = 32'hC000_0014;

    localparam int PB_LEVEL_BIT = 0;
    localparam int PB_EVENT_BIT = 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_SW,
        SEL_PB,
        SEL_PBCNT
    } io_sel_e;

    // Full 32-bit compare; anything else belongs to RAM or the output peripherals.
    function automatic io_sel_e io_decode(input logic [31:0] addr);
        io_sel_e sel;
        case (addr)
            IO_SW_ADDR:    sel = SEL_SW;
            IO_PB_ADDR:    sel = SEL_PB;
            IO_PBCNT_ADDR: sel = SEL_PBCNT;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_input_port_debounce_bit.sv
// One input bit: 2-FF synchronizer, then a sample window that only changes
// the debounced level when every sample in it agrees.
module debounce_bit #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic db
);

    logic sync1_q;
    logic sync2_q;
    logic db_q;
    logic db_d;
    logic [STABLE_SAMPLES-1:0] window;

    // The newest window entry is the synchronizer output itself; only older samples are stored.
    generate
        if (STABLE_SAMPLES > 1) begin : g_hist
            logic [STABLE_SAMPLES-2:0] hist_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    hist_q <= '0;
                end else if (tick) begin
                    hist_q <= window[STABLE_SAMPLES-2:0];
                end
            end
            assign window = {hist_q, sync2_q};
        end else begin : g_nohist
            assign window = sync2_q;
        end
    endgenerate

    always_comb begin
        db_d = db_q;
        if (tick) begin
            if (&window) begin
                db_d = 1'b1;
            end else if (~|window) begin
                db_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch / push-button input port: debounced levels, a sticky
// press event with write-1-to-clear, and a wrapping press counter.
import io_map_pkg::*;

module io_input_port #(
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STABLE_SAMPLES  = 3,
    parameter int PB_ACTIVE_LOW   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     a,
    input  logic            we,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic            hit,
    input  logic [SW_W-1:0] switches,
    input  logic            PB
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;
    logic             tick;
    logic [SW_W:0]    raw_in;
    logic [SW_W:0]    db_bits;
    logic [SW_W-1:0]  sw_db;
    logic             pb_db;
    logic             pb_db_q;
    logic             pb_rise;
    logic             pb_event_q;
    logic             pb_event_d;
    logic [7:0]       pb_count_q;
    logic [7:0]       pb_count_d;
    io_sel_e          sel;
    logic             clr_event;
    logic             clr_count;
    logic             unused_wd_bits;

    assign tick    = (presc_q == CNT_LAST);
    assign presc_d = tick ? '0 : presc_q + CNT_W'(1);

    // Push-button is the top bit so one generate loop covers every input.
    assign raw_in = {((PB_ACTIVE_LOW != 0) ? ~PB : PB), switches};

    generate
        for (genvar gi = 0; gi <= SW_W; gi++) begin : g_db
            debounce_bit #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .tick  (tick),
                .raw   (raw_in[gi]),
                .db    (db_bits[gi])
            );
        end
    endgenerate

    assign sw_db   = db_bits[SW_W-1:0];
    assign pb_db   = db_bits[SW_W];
    assign pb_rise = pb_db & ~pb_db_q;

    assign sel            = io_decode(a);
    assign clr_event      = we && (sel == SEL_PB) && wd[PB_EVENT_BIT];
    assign clr_count      = we && (sel == SEL_PBCNT);
    assign unused_wd_bits = ^{wd[31:PB_EVENT_BIT+1], wd[PB_EVENT_BIT-1:0]};

    // A press landing on the same edge as an acknowledge must never be lost.
    always_comb begin
        pb_event_d = pb_event_q;
        if (pb_rise) begin
            pb_event_d = 1'b1;
        end else if (clr_event) begin
            pb_event_d = 1'b0;
        end
        pb_count_d = clr_count ? 8'd0 : pb_count_q;
        if (pb_rise) begin
            pb_count_d = pb_count_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            pb_db_q    <= 1'b0;
            pb_event_q <= 1'b0;
            pb_count_q <= 8'd0;
        end else begin
            presc_q    <= presc_d;
            pb_db_q    <= pb_db;
            pb_event_q <= pb_event_d;
            pb_count_q <= pb_count_d;
        end
    end

    always_comb begin
        rd  = '0;
        hit = 1'b1;
        case (sel)
            SEL_SW: rd = 32'(sw_db);
            SEL_PB: begin
                rd[PB_LEVEL_BIT] = pb_db;
                rd[PB_EVENT_BIT] = pb_event_q;
            end
            SEL_PBCNT: rd = {24'b0, pb_count_q};
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_io_input_port.sv
// Directed + randomized bench for io_input_port; a history-based model
// predicts every register read after every clock edge.
import io_map_pkg::*;

module tb_io_input_port;

    localparam int SW_W = 10;
    localparam int DC   = 4;
    localparam int SS   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     a;
    logic            we;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic            hit;
    logic [SW_W-1:0] switches;
    logic            PB;

    always #10 clk = ~clk;

    io_input_port #(
        .SW_W(SW_W), .DEBOUNCE_CYCLES(DC), .STABLE_SAMPLES(SS), .PB_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .we(we), .wd(wd), .rd(rd), .hit(hit),
        .switches(switches), .PB(PB)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: raw level history since reset, plus the architectural registers.
    int            n;
    logic [SW_W:0] hist [int];
    logic [SW_W:0] m_db;
    logic          m_pb_prev;
    logic          m_event;
    logic [7:0]    m_count;
    logic          pb_pressed;

    function automatic logic [SW_W:0] hist_at(input int k);
        if (k >= 1 && hist.exists(k)) return hist[k];
        return '0;
    endfunction

    function automatic logic [32:0] model_read(input logic [31:0] addr);
        if (addr == IO_SW_ADDR)    return {1'b1, 22'b0, m_db[SW_W-1:0]};
        if (addr == IO_PB_ADDR)    return {1'b1, 30'b0, m_event, m_db[SW_W]};
        if (addr == IO_PBCNT_ADDR) return {1'b1, 24'b0, m_count};
        return 33'b0;
    endfunction

    // A new level is accepted at tick edge n when the raw level seen 2 edges
    // earlier, and at the same phase of the previous SS-1 tick periods, agree.
    task automatic model_edge(input logic rst, input logic [31:0] addr, input logic wen,
                              input logic [31:0] wdat, input logic [SW_W:0] raw);
        logic rise;
        logic [SW_W:0] s;
        if (rst) begin
            n = 0; hist.delete(); m_db = '0; m_pb_prev = 0; m_event = 0; m_count = 0;
        end else begin
            rise = m_db[SW_W] & ~m_pb_prev;
            if (rise) m_event = 1'b1;
            else if (wen && addr == IO_PB_ADDR && wdat[1]) m_event = 1'b0;
            if (wen && addr == IO_PBCNT_ADDR) m_count = 8'd0;
            if (rise) m_count = m_count + 8'd1;
            m_pb_prev = m_db[SW_W];
            n++;
            hist[n] = raw;
            if (n % DC == 0) begin
                for (int b = 0; b <= SW_W; b++) begin
                    int ones = 0;
                    for (int j = 0; j < SS; j++) begin
                        s = hist_at(n - 2 - j * DC);
                        ones += int'(s[b]);
                    end
                    if (ones == SS) m_db[b] = 1'b1;
                    else if (ones == 0) m_db[b] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic exp_hit, input logic [31:0] exp_rd);
        a = addr;
        #1;
        chk({tag, "/hit"}, {31'b0, hit}, {31'b0, exp_hit});
        chk({tag, "/rd"}, rd, exp_rd);
    endtask

    task automatic check_all();
        logic [31:0] addrs [4];
        logic [32:0] e;
        addrs[0] = IO_SW_ADDR; addrs[1] = IO_PB_ADDR; addrs[2] = IO_PBCNT_ADDR;
        addrs[3] = $urandom;
        for (int i = 0; i < 4; i++) begin
            e = model_read(addrs[i]);
            read_chk($sformatf("model@%08h", addrs[i]), addrs[i], e[32], e[31:0]);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] addr, input logic wen,
                        input logic [31:0] wdat);
        reset = rst; a = addr; we = wen; wd = wdat; PB = ~pb_pressed;
        @(posedge clk);
        model_edge(rst, addr, wen, wdat, {pb_pressed, switches});
        @(negedge clk);
        we = 1'b0;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, IO_SW_ADDR, 1'b0, 32'h0);
    endtask

    // Presses and holds; on the edge where a rise is pending, issue the given store.
    task automatic store_on_rise(input string tag, input logic [31:0] addr,
                                 input logic [31:0] exp_rd);
        logic found = 1'b0;
        pb_pressed = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_db[SW_W] && !m_pb_prev) begin
                step(1'b0, addr, 1'b1, 32'h2);
                found = 1'b1;
                read_chk(tag, addr, 1'b1, exp_rd);
            end else begin
                idle(1);
            end
        end
        chk({tag, "_rise_seen"}, {31'b0, found}, 32'h1);
        idle(4);
        pb_pressed = 1'b0;
        idle(24);
    endtask

    initial begin
        pb_pressed = 1'b0; switches = '0; reset = 1'b1; a = '0; we = 1'b0; wd = '0; PB = 1'b1;
        @(negedge clk);
        step(1'b1, IO_SW_ADDR, 1'b0, 32'h0);
        step(1'b1, IO_SW_ADDR, 1'b0, 32'h0);
        read_chk("reset_pb", IO_PB_ADDR, 1'b1, 32'h0);
        read_chk("reset_cnt", IO_PBCNT_ADDR, 1'b1, 32'h0);

        // Switch acceptance window
        switches = 10'h2A5;
        for (int i = 1; i <= 18; i++) begin
            idle(1);
            if (i <= 8) read_chk("sw_early", IO_SW_ADDR, 1'b1, 32'h0);
        end
        read_chk("sw_settled", IO_SW_ADDR, 1'b1, 32'h0000_02A5);

        // Short glitch press is rejected
        pb_pressed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            read_chk("short_pb", IO_PB_ADDR, 1'b1, 32'h0);
        end
        pb_pressed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            read_chk("short_pb_rel", IO_PB_ADDR, 1'b1, 32'h0);
        end
        read_chk("short_cnt", IO_PBCNT_ADDR, 1'b1, 32'h0);

        // Clean press, release, acknowledge
        pb_pressed = 1'b1; idle(20);
        read_chk("long_pressed", IO_PB_ADDR, 1'b1, 32'h3);
        pb_pressed = 1'b0; idle(20);
        read_chk("long_released", IO_PB_ADDR, 1'b1, 32'h2);
        step(1'b0, IO_PB_ADDR, 1'b1, 32'h2);
        read_chk("w1c_pb", IO_PB_ADDR, 1'b1, 32'h0);
        read_chk("w1c_cnt", IO_PBCNT_ADDR, 1'b1, 32'h1);

        // Same-edge collisions
        store_on_rise("w1c_vs_rise", IO_PB_ADDR, 32'h3);
        store_on_rise("clr_vs_rise", IO_PBCNT_ADDR, 32'h1);

        // Store to the read-only switch register changes nothing
        step(1'b0, IO_SW_ADDR, 1'b1, 32'hFFFF_FFFF);
        read_chk("sw_store_sw", IO_SW_ADDR, 1'b1, 32'h0000_02A5);
        read_chk("sw_store_cnt", IO_PBCNT_ADDR, 1'b1, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] addrs [3];
            addrs[0] = IO_SW_ADDR; addrs[1] = IO_PB_ADDR; addrs[2] = IO_PBCNT_ADDR;
            if ($urandom_range(29) == 0) switches = SW_W'($urandom);
            if ($urandom_range(39) == 0) pb_pressed = ~pb_pressed;
            if ($urandom_range(9) == 0)
                step(1'b0, addrs[$urandom_range(2)], 1'b1, $urandom);
            else
                step(1'b0, $urandom, 1'b0, $urandom);
        end

        // Counter wrap after 256 presses
        pb_pressed = 1'b0;
        step(1'b1, IO_SW_ADDR, 1'b0, 32'h0);
        for (int p = 0; p < 256; p++) begin
            pb_pressed = 1'b1; idle(24);
            pb_pressed = 1'b0; idle(24);
        end
        read_chk("wrap_cnt", IO_PBCNT_ADDR, 1'b1, 32'h0);
        read_chk("wrap_pb", IO_PB_ADDR, 1'b1, 32'h2);

        // Reset while pressed
        pb_pressed = 1'b1; idle(20);
        step(1'b1, IO_SW_ADDR, 1'b0, 32'h0);
        read_chk("rst_mid_sw", IO_SW_ADDR, 1'b1, 32'h0);
        read_chk("rst_mid_pb", IO_PB_ADDR, 1'b1, 32'h0);
        read_chk("rst_mid_cnt", IO_PBCNT_ADDR, 1'b1, 32'h0);
        pb_pressed = 1'b0;
        idle(4);

        read_chk("miss_addr", 32'h0000_0040, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
